// File: rtl/primecheck_pkg.sv
// Shared definitions for the primality checker: FSM state encoding and loop constants.
package primecheck_pkg;

    typedef enum logic [2:0] {
        S_READY        = 3'd0,
        S_ERROR        = 3'd1,
        S_CHECK_SMALL  = 3'd2,
        S_NEXT_DIVISOR = 3'd3,
        S_DIVIDE_START = 3'd4,
        S_DIVIDE_WAIT  = 3'd5
    } state_e;

    // Trial division starts at 3; its square seeds the termination test.
    localparam int FIRST_DIV    = 3;
    localparam int FIRST_DIV_SQ = 9;

endpackage

// File: rtl/primecheck_divrem.sv
// Bit-serial restoring divider producing the remainder of dividend/divisor in WIDTH cycles.
module primecheck_divrem #(
    parameter  int WIDTH_LOG = 4,
    localparam int W         = 1 << WIDTH_LOG
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         go_i,
    input  logic [W-1:0] dividend_i,
    input  logic [W-1:0] divisor_i,
    output logic         ready_o,
    output logic         error_o,
    output logic [W-1:0] rem_o
);

    logic               busy_q, busy_d;
    logic               err_q, err_d;
    logic [WIDTH_LOG:0] cnt_q, cnt_d;
    logic [W-1:0]       dvd_q, dvd_d;
    logic [W-1:0]       dvs_q, dvs_d;
    logic [W-1:0]       rem_q, rem_d;
    logic [W:0]         trial;

    always_comb begin
        busy_d = busy_q;
        err_d  = err_q;
        cnt_d  = cnt_q;
        dvd_d  = dvd_q;
        dvs_d  = dvs_q;
        rem_d  = rem_q;
        trial  = {rem_q, dvd_q[W-1]};
        if (!busy_q) begin
            if (go_i) begin
                if (divisor_i == '0) begin
                    err_d = 1'b1;
                end else begin
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                    cnt_d  = (WIDTH_LOG+1)'(W);
                    dvd_d  = dividend_i;
                    dvs_d  = divisor_i;
                    rem_d  = '0;
                end
            end
        end else begin
            // One quotient bit per cycle; only the partial remainder is kept.
            dvd_d = dvd_q << 1;
            if (trial >= {1'b0, dvs_q}) rem_d = W'(trial - {1'b0, dvs_q});
            else                        rem_d = trial[W-1:0];
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == (WIDTH_LOG+1)'(1)) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= 1'b0;
            err_q  <= 1'b0;
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            rem_q  <= '0;
        end else begin
            busy_q <= busy_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
            dvd_q  <= dvd_d;
            dvs_q  <= dvs_d;
            rem_q  <= rem_d;
        end
    end

    assign ready_o = ~busy_q;
    assign error_o = err_q;
    assign rem_o   = rem_q;

endmodule

// File: rtl/primecheck.sv
// Primality checker: resolves small/even operands directly, otherwise trial-divides by odd
// divisors up to sqrt(num) using the serial divider.
module primecheck
    import primecheck_pkg::*;
#(
    parameter  int WIDTH_LOG = 4,
    localparam int WIDTH     = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] num,
    output logic             ready,
    output logic             error,
    output logic             prime,
    output logic [WIDTH-1:0] factor
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] num_q, num_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] sq_q, sq_d;
    logic             ready_q, ready_d;
    logic             error_q, error_d;
    logic             prime_q, prime_d;
    logic [WIDTH-1:0] factor_q, factor_d;
    logic             dr_go, dr_ready, dr_error;
    logic [WIDTH-1:0] dr_rem;

    // (d+2)^2 = d^2 + 4d + 4; a wrapped sum saturates so the loop ends as prime.
    function automatic logic [WIDTH-1:0] sq_step(input logic [WIDTH-1:0] sq,
                                                 input logic [WIDTH-1:0] d);
        logic [WIDTH-1:0] nxt;
        nxt = sq + (d << 2) + WIDTH'(4);
        return (nxt <= sq) ? '1 : nxt;
    endfunction

    primecheck_divrem #(.WIDTH_LOG(WIDTH_LOG)) u_divrem (
        .clk_i      (clk),
        .rst_i      (~rst),
        .go_i       (dr_go),
        .dividend_i (num_q),
        .divisor_i  (div_q),
        .ready_o    (dr_ready),
        .error_o    (dr_error),
        .rem_o      (dr_rem)
    );

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        div_d    = div_q;
        sq_d     = sq_q;
        error_d  = error_q;
        prime_d  = prime_q;
        factor_d = factor_q;
        dr_go    = 1'b0;
        case (state_q)
            S_READY, S_ERROR: begin
                if (go) begin
                    num_d   = num;
                    error_d = 1'b0;
                    state_d = S_CHECK_SMALL;
                end
            end
            S_CHECK_SMALL: begin
                state_d = S_READY;
                if (num_q < WIDTH'(2)) begin
                    prime_d  = 1'b0;
                    factor_d = '0;
                end else if (num_q < WIDTH'(4)) begin
                    prime_d  = 1'b1;
                    factor_d = num_q;
                end else if (!num_q[0]) begin
                    prime_d  = 1'b0;
                    factor_d = WIDTH'(2);
                end else begin
                    div_d   = WIDTH'(FIRST_DIV);
                    sq_d    = WIDTH'(FIRST_DIV_SQ);
                    state_d = S_NEXT_DIVISOR;
                end
            end
            S_NEXT_DIVISOR: begin
                if (sq_q > num_q || &sq_q) begin
                    prime_d  = 1'b1;
                    factor_d = num_q;
                    state_d  = S_READY;
                end else begin
                    dr_go   = 1'b1;
                    state_d = S_DIVIDE_START;
                end
            end
            S_DIVIDE_START: state_d = S_DIVIDE_WAIT;
            S_DIVIDE_WAIT: begin
                if (dr_error) begin
                    error_d  = 1'b1;
                    prime_d  = 1'b0;
                    factor_d = '0;
                    state_d  = S_ERROR;
                end else if (dr_ready) begin
                    if (dr_rem == '0) begin
                        prime_d  = 1'b0;
                        factor_d = div_q;
                        state_d  = S_READY;
                    end else begin
                        div_d   = div_q + WIDTH'(2);
                        sq_d    = sq_step(sq_q, div_q);
                        state_d = S_NEXT_DIVISOR;
                    end
                end
            end
            default: begin
`ifdef SYNTHESIS
                state_d = S_READY;
`else
                state_d = state_e'('x);
`endif
            end
        endcase
        ready_d = (state_d == S_READY) || (state_d == S_ERROR);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_READY;
            num_q    <= '0;
            div_q    <= '0;
            sq_q     <= '0;
            ready_q  <= 1'b1;
            error_q  <= 1'b0;
            prime_q  <= 1'b0;
            factor_q <= '0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            div_q    <= div_d;
            sq_q     <= sq_d;
            ready_q  <= ready_d;
            error_q  <= error_d;
            prime_q  <= prime_d;
            factor_q <= factor_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst && dr_go) assert (div_q != '0) else $error("divider started with zero divisor");
    end

    assign ready  = ready_q;
    assign error  = error_q;
    assign prime  = prime_q;
    assign factor = factor_q;

endmodule
